// File: rtl/common_dffram_fifo_ctrl.sv
`default_nettype none
// common_dffram_fifo_ctrl: first-word fall-through FIFO controller for an external flop RAM.
// Revision: 1.0
module common_dffram_fifo_ctrl #(
   parameter int FIFO_WIDTH        = 8,
   parameter int FIFO_DEPTH        = 4,
   parameter int ALMOST_FULL_LEVEL = FIFO_DEPTH - 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          s_valid,
   input  logic [FIFO_WIDTH-1:0]         s_data,
   output logic                          s_ready,
   output logic                          m_valid,
   output logic [FIFO_WIDTH-1:0]         m_data,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH)-1:0] ram_addra,
   output logic                          ram_ena,
   output logic                          ram_wea,
   output logic [FIFO_WIDTH-1:0]         ram_dina,
   output logic [$clog2(FIFO_DEPTH)-1:0] ram_addrb,
   input  logic [FIFO_WIDTH-1:0]         ram_doutb,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_nxt;
   logic [PW-1:0] rd_nxt;
   logic [PW-1:0] cnt;
   logic          push;
   logic          pop;

   // The MSB of each pointer is a wrap flag, so equal addresses are disambiguated.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign s_ready = ~full & ~flush;
   assign m_valid = ~empty & ~flush;
   assign push    = s_valid & s_ready;
   assign pop     = m_valid & m_ready;

   // Writes are held off while reset is low so no RAM access leaks out of reset.
   assign ram_ena   = push & reset;
   assign ram_wea   = push & reset;
   assign ram_addra = wr_ptr[AW-1:0];
   assign ram_dina  = s_data;
   assign ram_addrb = rd_ptr[AW-1:0];
   assign m_data    = ram_doutb;

   assign count       = cnt;
   assign almost_full = (cnt >= PW'(ALMOST_FULL_LEVEL));

   always_comb begin
      wr_nxt = wr_ptr;
      rd_nxt = rd_ptr;
      if (flush) begin
         wr_nxt = '0;
         rd_nxt = '0;
      end else begin
         if (push) wr_nxt = wr_ptr + PW'(1);
         if (pop)  rd_nxt = rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         cnt    <= wr_nxt - rd_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_common_dffram_fifo_ctrl.sv
`default_nettype none
// tb_common_dffram_fifo_ctrl: directed plus random traffic against a queue-based FIFO model.
// Revision: 1.0
module tb_common_dffram_fifo_ctrl;

   localparam int W     = 8;
   localparam int D     = 4;
   localparam int AFL   = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         flush = 1'b0;
   logic         s_valid = 1'b0;
   logic [W-1:0] s_data = '0;
   logic         s_ready;
   logic         m_valid;
   logic [W-1:0] m_data;
   logic         m_ready = 1'b0;
   logic [1:0]   ram_addra;
   logic         ram_ena;
   logic         ram_wea;
   logic [W-1:0] ram_dina;
   logic [1:0]   ram_addrb;
   logic [W-1:0] ram_doutb;
   logic [2:0]   count;
   logic         full;
   logic         empty;
   logic         almost_full;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] mem [D];

   always #5 clk = ~clk;

   common_dffram_fifo_ctrl #(
      .FIFO_WIDTH(W), .FIFO_DEPTH(D), .ALMOST_FULL_LEVEL(AFL)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .ram_addra(ram_addra), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_dina(ram_dina),
      .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
      .count(count), .full(full), .empty(empty), .almost_full(almost_full)
   );

   // Attached RAM: synchronous write, combinational read, never cleared by the FIFO.
   initial for (int i = 0; i < D; i++) mem[i] = '0;
   always @(posedge clk) if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
   assign ram_doutb = mem[ram_addrb];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of accepted words plus write/read slot indices.
   logic [W-1:0] q [$];
   int wr_idx = 0;
   int rd_idx = 0;

   initial begin : monitor
      bit e_sready, e_mvalid, e_push, e_pop;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            q.delete();
            wr_idx = 0;
            rd_idx = 0;
         end
         e_sready = (q.size() < D) && !flush;
         e_mvalid = (q.size() > 0) && !flush;
         e_push   = s_valid && e_sready && reset;
         e_pop    = m_valid === 1'b1 && e_mvalid && m_ready && reset;
         check("count",       32'(count),       32'(q.size()));
         check("empty",       32'(empty),       32'(q.size() == 0));
         check("full",        32'(full),        32'(q.size() == D));
         check("almost_full", 32'(almost_full), 32'(q.size() >= AFL));
         check("s_ready",     32'(s_ready),     32'(e_sready));
         check("m_valid",     32'(m_valid),     32'(e_mvalid));
         check("ram_wea",     32'(ram_wea),     32'(e_push));
         check("ram_ena",     32'(ram_ena),     32'(e_push));
         check("ram_addra",   32'(ram_addra),   32'(wr_idx));
         check("ram_addrb",   32'(ram_addrb),   32'(rd_idx));
         if (e_push) check("ram_dina", 32'(ram_dina), 32'(s_data));
         if (e_mvalid && m_ready && reset) begin
            check("m_data", 32'(m_data), 32'(q[0]));
         end
         if (reset) begin
            if (flush) begin
               q.delete();
               wr_idx = 0;
               rd_idx = 0;
            end else begin
               if (e_mvalid && m_ready) begin
                  void'(q.pop_front());
                  rd_idx = (rd_idx + 1) % D;
               end
               if (e_push) begin
                  q.push_back(s_data);
                  wr_idx = (wr_idx + 1) % D;
               end
            end
         end
         if (e_pop) begin end
      end
   end

   task automatic cyc(input logic rst, input logic sv, input logic [W-1:0] d,
                      input logic mr, input logic fl);
      @(negedge clk);
      reset   = rst;
      s_valid = sv;
      s_data  = d;
      m_ready = mr;
      flush   = fl;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not end, limit %0d", 2000000);
      $fatal(1);
   end

   initial begin : stimulus
      logic [W-1:0] seq [4];
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
      // Held in reset, including a write request that must not reach the RAM.
      cyc(0, 0, 8'h00, 0, 0);
      cyc(0, 1, 8'hEE, 0, 0);
      cyc(0, 0, 8'h00, 0, 0);
      // Fill to full with the consumer stalled, then try one more.
      for (int i = 0; i < 4; i++) cyc(1, 1, seq[i], 0, 0);
      cyc(1, 1, 8'h99, 0, 0);
      // From full: push and pop together, only the pop proceeds.
      cyc(1, 1, 8'h66, 1, 0);
      cyc(1, 0, 8'h00, 1, 0);
      // Steady streaming at count 2, read address wraps.
      for (int i = 0; i < 10; i++) cyc(1, 1, 8'(8'hB0 + i), 1, 0);
      cyc(1, 1, 8'h77, 0, 0);
      // Flush at count 3 with traffic requested in the same cycle.
      cyc(1, 1, 8'h88, 1, 1);
      cyc(1, 1, 8'h55, 0, 0);
      cyc(1, 0, 8'h00, 1, 0);
      cyc(1, 0, 8'h00, 0, 0);
      // Reset mid-stream at count 2.
      cyc(1, 1, 8'hC1, 0, 0);
      cyc(1, 1, 8'hC2, 0, 0);
      cyc(0, 1, 8'hC3, 1, 0);
      cyc(1, 1, 8'hA5, 0, 0);
      cyc(1, 0, 8'h00, 1, 0);
      cyc(1, 0, 8'h00, 0, 0);
      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
             1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      end
      cyc(1, 0, 8'h00, 1, 0);
      @(negedge clk);
      #4;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/common_dffram_fifo_ctrl.md
COMMON_DFFRAM_FIFO_CTRL -- requirements
Module: common_dffram_fifo_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, data width in bits; equals the attached RAM's RAM_WIDTH.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entry count; power of two, >=2; equals the attached RAM's RAM_DEPTH.
REQ-003 SHALL have parameter ALMOST_FULL_LEVEL, default FIFO_DEPTH-1, count at or above which almost_full asserts; range 1..FIFO_DEPTH.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush, input, 1, synchronous clear of all entries.
REQ-007 SHALL have port s_valid, input, 1, upstream write request.
REQ-008 SHALL have port s_data, input, FIFO_WIDTH, upstream write data.
REQ-009 SHALL have port s_ready, output, 1, FIFO can accept.
REQ-010 SHALL have port m_valid, output, 1, head entry available.
REQ-011 SHALL have port m_data, output, FIFO_WIDTH, head entry data.
REQ-012 SHALL have port m_ready, input, 1, downstream consumes head.
REQ-013 SHALL have port ram_addra, output, $clog2(FIFO_DEPTH), binary write address to RAM port A.
REQ-014 SHALL have ports ram_ena and ram_wea, output, 1 each, RAM port A enable and write enable.
REQ-015 SHALL have port ram_dina, output, FIFO_WIDTH, RAM port A write data.
REQ-016 SHALL have port ram_addrb, output, $clog2(FIFO_DEPTH), binary read address to RAM port B.
REQ-017 SHALL have port ram_doutb, input, FIFO_WIDTH, combinational RAM port B read data.
REQ-018 SHALL have ports count (output, $clog2(FIFO_DEPTH)+1, occupied entries), full, empty and almost_full (output, 1 each).

Function
REQ-019 SHALL keep wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH)+1 bits; low bits are the address, MSB is the wrap flag.
REQ-020 SHALL define push = s_valid & s_ready and pop = m_valid & m_ready, evaluated each cycle.
REQ-021 SHALL drive s_ready = ~full & ~flush, and m_valid = ~empty & ~flush.
REQ-022 SHALL drive ram_ena = ram_wea = push, ram_addra = wr_ptr low bits, ram_dina = s_data, all combinationally.
REQ-023 SHALL drive ram_addrb = rd_ptr low bits and m_data = ram_doutb (first-word fall-through, zero-cycle read latency).
REQ-024 SHALL increment wr_ptr by 1 mod 2*FIFO_DEPTH on push and rd_ptr likewise on pop, at the clock edge.
REQ-025 SHALL derive empty = (wr_ptr == rd_ptr); full = low bits equal and MSBs differ; count = wr_ptr - rd_ptr modulo 2*FIFO_DEPTH.
REQ-026 SHALL register count and drive almost_full = (count >= ALMOST_FULL_LEVEL).
REQ-027 SHALL keep count unchanged on a simultaneous push and pop; a pushed word becomes visible on m_data no earlier than the cycle after its push.
REQ-028 SHALL block a push when full even if pop is asserted in the same cycle.
REQ-029 SHALL wrap pointer low bits from FIFO_DEPTH-1 to 0 and toggle the MSB on each wrap.
REQ-030 SHALL, on flush, set both pointers and count to 0 at the next edge and suppress push and pop in that cycle.
REQ-031 SHALL not modify RAM contents on flush or reset; stale data is unreachable because empty = 1.

Reset
REQ-032 SHALL, while reset = 0, asynchronously force wr_ptr = rd_ptr = 0 and count = 0, giving empty = 1, full = 0, almost_full = 0, s_ready = 1, m_valid = 0, ram_ena = ram_wea = 0.
REQ-033 SHALL abandon any in-progress push or pop when reset asserts mid-transfer; no pointer movement occurs on the edge where reset is low.
REQ-034 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification (FIFO_WIDTH=8, FIFO_DEPTH=4, ALMOST_FULL_LEVEL=3, RAM model attached)
REQ-035 SHALL cover: reset low -> empty=1, count=0, s_ready=1, m_valid=0, ram_wea=0.
REQ-036 SHALL cover: push 0x11, 0x22, 0x33, 0x44 with m_ready=0 -> almost_full=1 after the 3rd push, full=1 and count=4 after the 4th, s_ready=0; ram_addra sequence 0,1,2,3.
REQ-037 SHALL cover: from full, s_valid=1 and m_ready=1 for 1 cycle -> pop of 0x11 only, count=3, no RAM write.
REQ-038 SHALL cover: 10 cycles of continuous push and pop at count=2 -> count stays 2, data ordered, ram_addrb wraps 3->0.
REQ-039 SHALL cover: flush at count=3 -> next cycle empty=1, count=0, m_valid=0; the next push of 0x55 is read back as 0x55.
REQ-040 SHALL cover: reset asserted mid-stream at count=2 -> immediate empty=1, count=0; after release, push 0xA5 -> m_data=0xA5 the next cycle.
